// File: rtl/video_delay_line.sv
// Run-time programmable delay line for video sideband and pixel data.
// A sample taken on ce edge n is presented on data_out right after ce edge
// n+D-1. The delay D is reloadable. The primed flag marks the point where
// data_out carries a sample captured since the last reset or delay reload.
module video_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               MAX_DEPTH = 22,
  parameter int               DEF_DELAY = 22,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter bit               MASK_UNPR = 1'b1,
  localparam int              DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             cfg_load,
  input  logic [DW-1:0]    delay_cfg,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             primed
);

  // The output register counts as the last stage, so at most MAX_DEPTH-1
  // chain stages are needed. One dummy stage is kept when MAX_DEPTH=1 so
  // that the array never has zero size.
  localparam int SR_N = (MAX_DEPTH > 1) ? MAX_DEPTH - 1 : 1;
  localparam int IW   = (SR_N > 1) ? $clog2(SR_N) : 1;

  logic [WIDTH-1:0] sr_q [SR_N];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] tap;
  logic [DW-1:0]    d_q, d_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    cnt_inc;
  logic [DW-1:0]    cfg_clamped;
  logic             primed_q, primed_d;

  // Shift chain: stage k holds the sample captured k+1 ce edges ago.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SR_N; i++) sr_q[i] <= RST_VAL;
    end else if (ce) begin
      sr_q[0] <= data_in;
      for (int i = 1; i < SR_N; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  // Tap selection: for D=1 the output register loads data_in directly,
  // otherwise it loads chain stage D-2.
  always_comb begin
    tap = data_in;
    if (d_q > DW'(1)) tap = sr_q[IW'(d_q - DW'(2))];
  end

  // Clamp the requested delay into 1..MAX_DEPTH; the saturating fill count
  // never exceeds MAX_DEPTH, so a compare against D is always reachable.
  always_comb begin
    cfg_clamped = delay_cfg;
    if (delay_cfg == '0)                    cfg_clamped = DW'(1);
    else if (delay_cfg > DW'(MAX_DEPTH))    cfg_clamped = DW'(MAX_DEPTH);
    cnt_inc = (cnt_q == DW'(MAX_DEPTH)) ? cnt_q : cnt_q + DW'(1);
  end

  // Next-state for output data, delay, fill counter and primed flag. A
  // reload restarts priming but keeps the chain; a concurrent ce sample is
  // the first one counted toward the new delay.
  always_comb begin
    dout_d   = dout_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    if (ce) begin
      dout_d = tap;
      cnt_d  = cnt_inc;
      if (cnt_inc >= d_q) primed_d = 1'b1;
    end
    if (cfg_load) begin
      d_d      = cfg_clamped;
      cnt_d    = ce ? DW'(1) : '0;
      primed_d = 1'b0;
    end
  end

  // Control and output registers; reset overrides ce and cfg_load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q   <= RST_VAL;
      d_q      <= DW'(DEF_DELAY);
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  // Output masking selects between registers only, so there is no path
  // from any input to data_out within the same cycle.
  generate
    if (MASK_UNPR) begin : g_mask
      assign data_out = primed_q ? dout_q : RST_VAL;
    end else begin : g_raw
      assign data_out = dout_q;
    end
  endgenerate

  assign primed = primed_q;

endmodule

// File: tb/tb_video_delay_line.sv
// Self-checking bench for video_delay_line: a default 3-bit/22-deep masked
// instance and an 8-bit/64-deep unmasked instance, each compared against a
// sample-history reference model.
module tb_video_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_ce, a_load;
  logic [4:0] a_cfg;
  logic [2:0] a_din, a_out;
  logic       a_primed;

  logic       b_rst_n, b_ce, b_load;
  logic [6:0] b_cfg;
  logic [7:0] b_din, b_out;
  logic       b_primed;

  video_delay_line dut_a (
    .clk(clk), .rst_n(a_rst_n), .ce(a_ce), .cfg_load(a_load),
    .delay_cfg(a_cfg), .data_in(a_din), .data_out(a_out), .primed(a_primed)
  );

  video_delay_line #(
    .WIDTH(8), .MAX_DEPTH(64), .DEF_DELAY(64), .RST_VAL(8'h00), .MASK_UNPR(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n), .ce(b_ce), .cfg_load(b_load),
    .delay_cfg(b_cfg), .data_in(b_din), .data_out(b_out), .primed(b_primed)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: full history of captured samples since reset.
  // Output after a ce edge = sample captured D-1 ce edges earlier
  // (RST value if that predates the reset).
  logic [7:0] m_hist [2][4096];
  int         m_n    [2];
  int         m_base [2];
  int         m_D    [2];
  int         m_cnt  [2];
  bit         m_primed [2];
  logic [7:0] m_raw  [2];
  logic [7:0] m_out  [2];

  task automatic step(input int inst, input bit rst, input bit ce, input bit load,
                      input int cfg, input logic [7:0] din);
    int mx, src, c, dused;
    bit mask;
    logic [7:0] wm;
    mx   = (inst == 0) ? 22 : 64;
    mask = (inst == 0);
    wm   = (inst == 0) ? 8'h07 : 8'hFF;
    if (inst == 0) begin
      a_rst_n = rst; a_ce = ce; a_load = load; a_cfg = 5'(cfg); a_din = din[2:0];
      b_rst_n = 1'b1; b_ce = 1'b0; b_load = 1'b0;
      cfg = cfg & 31;
    end else begin
      b_rst_n = rst; b_ce = ce; b_load = load; b_cfg = 7'(cfg); b_din = din;
      a_rst_n = 1'b1; a_ce = 1'b0; a_load = 1'b0;
      cfg = cfg & 127;
    end
    @(posedge clk);
    if (!rst) begin
      m_base[inst] = m_n[inst]; m_D[inst] = mx; m_cnt[inst] = 0;
      m_primed[inst] = 1'b0; m_raw[inst] = 8'h00;
    end else begin
      dused = m_D[inst];
      if (ce) begin
        m_hist[inst][m_n[inst] % 4096] = din & wm;
        m_n[inst]++;
        src = m_n[inst] - dused;
        m_raw[inst] = (src < m_base[inst]) ? 8'h00 : m_hist[inst][src % 4096];
      end
      if (load) begin
        c = cfg;
        if (c == 0) c = 1;
        if (c > mx) c = mx;
        m_D[inst] = c; m_cnt[inst] = ce ? 1 : 0; m_primed[inst] = 1'b0;
      end else if (ce) begin
        m_cnt[inst]++;
        if (m_cnt[inst] >= m_D[inst]) m_primed[inst] = 1'b1;
      end
    end
    m_out[inst] = (mask && !m_primed[inst]) ? 8'h00 : m_raw[inst];
    #1;
  endtask

  task automatic test_reset();
    step(0, 1'b0, 1'b1, 1'b1, 3, 8'h5);
    step(0, 1'b0, 1'b1, 1'b0, 0, 8'h6);
    step(1, 1'b0, 1'b1, 1'b0, 0, 8'hA5);
    step(1, 1'b0, 1'b1, 1'b0, 0, 8'h3C);
    checks++;
    if (a_out !== 3'd0 || a_primed !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: data_out=%0h primed=%0b expected 0/0", a_out, a_primed);
    end
    checks++;
    if (b_out !== 8'd0 || b_primed !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: data_out=%0h primed=%0b expected 0/0", b_out, b_primed);
    end
  endtask

  task automatic test_default_delay();
    for (int i = 0; i < 40; i++) begin
      step(0, 1'b1, 1'b1, 1'b0, 0, 8'(i + 1));
      checks++;
      if (a_out !== m_out[0][2:0] || a_primed !== m_primed[0]) begin
        errors++;
        $display("FAIL default_delay edge %0d: out=%0h primed=%0b expected %0h/%0b",
                 i + 1, a_out, a_primed, m_out[0][2:0], m_primed[0]);
      end
      if (i == 21) begin
        checks++;
        if (a_out !== 3'd1 || a_primed !== 1'b1) begin
          errors++;
          $display("FAIL default_first_valid: out=%0h primed=%0b expected 1/1", a_out, a_primed);
        end
      end
    end
  endtask

  task automatic test_load_d1();
    logic [7:0] x;
    step(0, 1'b1, 1'b1, 1'b1, 1, 8'($urandom));
    checks++;
    if (a_out !== 3'd0 || a_primed !== 1'b0) begin
      errors++;
      $display("FAIL load_d1_mask: out=%0h primed=%0b expected 0/0", a_out, a_primed);
    end
    for (int i = 0; i < 8; i++) begin
      x = 8'($urandom_range(0, 7));
      step(0, 1'b1, 1'b1, 1'b0, 0, x);
      checks++;
      if (a_out !== x[2:0] || a_primed !== 1'b1 || a_out !== m_out[0][2:0]) begin
        errors++;
        $display("FAIL load_d1 step %0d: out=%0h primed=%0b expected %0h/1",
                 i, a_out, a_primed, x[2:0]);
      end
    end
  endtask

  task automatic test_stall();
    bit pat [6] = '{1, 0, 0, 1, 1, 1};
    logic [2:0] prev;
    step(0, 1'b1, 1'b0, 1'b1, 4, 8'h0);
    for (int i = 0; i < 6; i++) begin
      prev = a_out;
      step(0, 1'b1, pat[i], 1'b0, 0, 8'($urandom));
      checks++;
      if (a_out !== m_out[0][2:0] || a_primed !== m_primed[0]) begin
        errors++;
        $display("FAIL stall step %0d: out=%0h primed=%0b expected %0h/%0b",
                 i, a_out, a_primed, m_out[0][2:0], m_primed[0]);
      end
      checks++;
      if (a_primed !== (i == 5)) begin
        errors++;
        $display("FAIL stall_primed step %0d: primed=%0b expected %0b", i, a_primed, (i == 5));
      end
      if (!pat[i]) begin
        checks++;
        if (a_out !== prev) begin
          errors++;
          $display("FAIL stall_frozen step %0d: out=%0h expected %0h", i, a_out, prev);
        end
      end
    end
    // Random stalls and reloads after priming.
    for (int i = 0; i < 80; i++) begin
      step(0, 1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           $urandom_range(0, 31), 8'($urandom));
      checks++;
      if (a_out !== m_out[0][2:0] || a_primed !== m_primed[0]) begin
        errors++;
        $display("FAIL random_stall step %0d: out=%0h primed=%0b expected %0h/%0b",
                 i, a_out, a_primed, m_out[0][2:0], m_primed[0]);
      end
    end
  endtask

  task automatic test_clamp();
    step(0, 1'b1, 1'b1, 1'b1, 0, 8'h2);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 1'b1, 1'b0, 0, 8'(i + 3));
      checks++;
      if (a_out !== 3'(i + 3) || a_primed !== 1'b1) begin
        errors++;
        $display("FAIL clamp_zero step %0d: out=%0h primed=%0b expected %0h/1",
                 i, a_out, a_primed, 3'(i + 3));
      end
    end
    step(0, 1'b1, 1'b1, 1'b1, 31, 8'h1);
    for (int i = 2; i <= 24; i++) begin
      step(0, 1'b1, 1'b1, 1'b0, 0, 8'($urandom));
      checks++;
      if (a_primed !== (i >= 22) || a_out !== m_out[0][2:0]) begin
        errors++;
        $display("FAIL clamp_max edge %0d: out=%0h primed=%0b expected %0h/%0b",
                 i, a_out, a_primed, m_out[0][2:0], (i >= 22));
      end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1'b1, 1'b1, 1'b1, 10, 8'($urandom));
    for (int i = 0; i < 49; i++) step(0, 1'b1, 1'b1, 1'b0, 0, 8'($urandom));
    checks++;
    if (a_primed !== 1'b1 || a_out !== m_out[0][2:0]) begin
      errors++;
      $display("FAIL reset_mid_pre: out=%0h primed=%0b expected %0h/1", a_out, a_primed, m_out[0][2:0]);
    end
    step(0, 1'b0, 1'b1, 1'b0, 0, 8'h7);
    checks++;
    if (a_out !== 3'd0 || a_primed !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%0h primed=%0b expected 0/0", a_out, a_primed);
    end
    for (int i = 1; i <= 24; i++) begin
      step(0, 1'b1, 1'b1, 1'b0, 0, (i == 1) ? 8'h5 : 8'h2);
      checks++;
      if (a_out !== m_out[0][2:0] || a_primed !== (i >= 22)) begin
        errors++;
        $display("FAIL reset_mid_reprime edge %0d: out=%0h primed=%0b expected %0h/%0b",
                 i, a_out, a_primed, m_out[0][2:0], (i >= 22));
      end
      if (i == 22) begin
        checks++;
        if (a_out !== 3'd5) begin
          errors++;
          $display("FAIL reset_mid_first: out=%0h expected 5", a_out);
        end
      end
    end
  endtask

  task automatic test_wide();
    step(1, 1'b0, 1'b0, 1'b0, 0, 8'h0);
    step(1, 1'b1, 1'b1, 1'b1, 64, 8'($urandom));
    for (int i = 1; i < 200; i++) begin
      step(1, 1'b1, ($urandom_range(0, 9) != 0), 1'b0, 0, 8'($urandom));
      checks++;
      if (b_out !== m_out[1] || b_primed !== m_primed[1]) begin
        errors++;
        $display("FAIL wide step %0d: out=%0h primed=%0b expected %0h/%0b",
                 i, b_out, b_primed, m_out[1], m_primed[1]);
      end
      if (!m_primed[1]) begin
        checks++;
        if (b_out !== 8'h00) begin
          errors++;
          $display("FAIL wide_unprimed step %0d: out=%0h expected 0", i, b_out);
        end
      end
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_ce = 1'b0; a_load = 1'b0; a_cfg = '0; a_din = '0;
    b_rst_n = 1'b0; b_ce = 1'b0; b_load = 1'b0; b_cfg = '0; b_din = '0;
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_base[k] = 0; m_D[k] = 0; m_cnt[k] = 0;
      m_primed[k] = 1'b0; m_raw[k] = 8'h00; m_out[k] = 8'h00;
    end
    test_reset();
    test_default_delay();
    test_load_d1();
    test_stall();
    test_clamp();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
